// File: rtl/hash_pkg.sv
// Shared state encoding and default sizing for the hash word assembler.
package hash_pkg;

  localparam int unsigned DefWordWidth = 32;
  localparam int unsigned DefNumWords  = 8;

  typedef enum logic {
    StCollect = 1'b0,
    StDone    = 1'b1
  } state_e;

  // Width needed to hold a count from 0 to n inclusive.
  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hash_word_assembler_if.sv
// Word-in / vector-out bus of the hash word assembler.
interface hash_word_assembler_if #(
  parameter int unsigned WORD_WIDTH = hash_pkg::DefWordWidth,
  parameter int unsigned NUM_WORDS  = hash_pkg::DefNumWords
);

  localparam int unsigned AddrW  = $clog2(NUM_WORDS);
  localparam int unsigned CountW = hash_pkg::count_width(NUM_WORDS);

  logic                            in_valid;
  logic                            in_ready;
  logic [AddrW-1:0]                in_addr;
  logic [WORD_WIDTH-1:0]           in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_WORDS*WORD_WIDTH-1:0] hash_vector;
  logic [CountW-1:0]               word_count;
  logic                            dup_error;
  logic                            range_error;

  modport master (
    output in_valid, in_addr, in_data, out_ready,
    input  in_ready, out_valid, hash_vector, word_count, dup_error, range_error
  );

  modport slave (
    input  in_valid, in_addr, in_data, out_ready,
    output in_ready, out_valid, hash_vector, word_count, dup_error, range_error
  );

endinterface

// File: rtl/hash_slot_map.sv
// Maps a word index to the bit offset of its slot in the assembled vector.
module hash_slot_map #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 8,
  parameter int unsigned WORD_ORDER = 0
) (
  input  logic [$clog2(NUM_WORDS)-1:0]            i_addr,
  output logic [$clog2(NUM_WORDS*WORD_WIDTH)-1:0] o_offset
);

  localparam int unsigned OffW = $clog2(NUM_WORDS * WORD_WIDTH);

  int unsigned w_slot;

  always_comb begin
    w_slot = 32'(i_addr);
    // Reversed order puts word 0 in the most significant slot.
    if (WORD_ORDER != 0) begin
      w_slot = NUM_WORDS - 1 - w_slot;
    end
    o_offset = OffW'(w_slot * WORD_WIDTH);
  end

endmodule

// File: rtl/hash_word_assembler.sv
// Collects indexed hash words in any order into one vector and holds the
// completed vector until the consumer takes it.
module hash_word_assembler
  import hash_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DefWordWidth,
  parameter int unsigned NUM_WORDS  = DefNumWords,
  parameter int unsigned WORD_ORDER = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  hash_word_assembler_if.slave io_bus
);

  localparam int unsigned AddrW    = $clog2(NUM_WORDS);
  localparam int unsigned AddrExtW = AddrW + 1;
  localparam int unsigned CountW   = count_width(NUM_WORDS);
  localparam int unsigned VecW     = NUM_WORDS * WORD_WIDTH;
  localparam int unsigned OffW     = $clog2(VecW);
  localparam logic [AddrW:0] NumWordsExt = AddrExtW'(NUM_WORDS);

  state_e                r_state;
  logic [VecW-1:0]       r_vector;
  logic [NUM_WORDS-1:0]  r_mask;
  logic [CountW-1:0]     r_count;
  logic                  r_dup;
  logic                  r_range;

  logic                  w_in_range;
  logic                  w_accept;
  logic                  w_hit;
  logic [NUM_WORDS-1:0]  w_mask_next;
  logic [OffW-1:0]       w_offset;

  hash_slot_map #(
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_WORDS  (NUM_WORDS),
    .WORD_ORDER (WORD_ORDER)
  ) u_slot_map (
    .i_addr   (io_bus.in_addr),
    .o_offset (w_offset)
  );

  assign w_in_range = {1'b0, io_bus.in_addr} < NumWordsExt;
  assign w_accept   = io_bus.in_valid && (r_state == StCollect) && w_in_range;
  assign w_hit      = r_mask[io_bus.in_addr];

  always_comb begin
    w_mask_next = r_mask;
    if (w_accept) begin
      w_mask_next[io_bus.in_addr] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_state  <= StCollect;
      r_vector <= '0;
      r_mask   <= '0;
      r_count  <= '0;
      r_dup    <= 1'b0;
      r_range  <= 1'b0;
    end else begin
      r_dup   <= 1'b0;
      r_range <= 1'b0;
      case (r_state)
        StCollect: begin
          if (io_bus.in_valid && !w_in_range) begin
            r_range <= 1'b1;
          end
          if (w_accept) begin
            r_vector[w_offset +: WORD_WIDTH] <= io_bus.in_data;
            r_mask <= w_mask_next;
            // A rewrite replaces the slot but must not count twice.
            if (w_hit) begin
              r_dup <= 1'b1;
            end else begin
              r_count <= r_count + CountW'(1);
            end
            if (&w_mask_next) begin
              r_state <= StDone;
            end
          end
        end
        StDone: begin
          if (io_bus.out_ready) begin
            r_state  <= StCollect;
            r_vector <= '0;
            r_mask   <= '0;
            r_count  <= '0;
          end
        end
        default: r_state <= StCollect;
      endcase
    end
  end

  assign io_bus.in_ready    = (r_state == StCollect);
  assign io_bus.out_valid   = (r_state == StDone);
  assign io_bus.hash_vector = r_vector;
  assign io_bus.word_count  = r_count;
  assign io_bus.dup_error   = r_dup;
  assign io_bus.range_error = r_range;

endmodule

// File: tb/tb_hash_word_assembler.sv
// Bench for hash_word_assembler: a slot-array model checks the default instance
// every cycle; directed literals cover reversed order and a non-power-of-two size.
module tb_hash_word_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic flush_a;
  bit   chk_en = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  hash_word_assembler_if #(.WORD_WIDTH(32), .NUM_WORDS(8)) a_if ();
  hash_word_assembler_if #(.WORD_WIDTH(32), .NUM_WORDS(8)) b_if ();
  hash_word_assembler_if #(.WORD_WIDTH(32), .NUM_WORDS(6)) c_if ();

  hash_word_assembler #(.WORD_WIDTH(32), .NUM_WORDS(8), .WORD_ORDER(0)) u_dut_a (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush_a),
    .io_bus  (a_if)
  );

  hash_word_assembler #(.WORD_WIDTH(32), .NUM_WORDS(8), .WORD_ORDER(1)) u_dut_b (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (1'b0),
    .io_bus  (b_if)
  );

  hash_word_assembler #(.WORD_WIDTH(32), .NUM_WORDS(6), .WORD_ORDER(0)) u_dut_c (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (1'b0),
    .io_bus  (c_if)
  );

  task automatic checkv(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // Model of instance A: which slots hold which word; complete means all filled.
  logic [31:0] m_words [8];
  logic [7:0]  m_filled;
  logic        m_dup;

  function automatic logic [255:0] m_vector();
    logic [255:0] v = '0;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = m_words[i];
    return v;
  endfunction

  always @(posedge clk) begin
    m_dup <= 1'b0;
    if (rst || flush_a || ((&m_filled) && a_if.out_ready)) begin
      m_filled <= '0;
      for (int i = 0; i < 8; i++) m_words[i] <= '0;
    end else if (!(&m_filled) && a_if.in_valid) begin
      m_dup                    <= m_filled[a_if.in_addr];
      m_words[a_if.in_addr]    <= a_if.in_data;
      m_filled[a_if.in_addr]   <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkb("a_in_ready", a_if.in_ready, !(&m_filled));
      checkb("a_out_valid", a_if.out_valid, &m_filled);
      checkb("a_dup_error", a_if.dup_error, m_dup);
      checkb("a_range_error", a_if.range_error, 1'b0);
      checkv("a_hash_vector", a_if.hash_vector, m_vector());
      checkv("a_word_count", 256'(a_if.word_count), 256'($countones(m_filled)));
    end
  end

  task automatic drive_a(input logic v, input logic [2:0] ad, input logic [31:0] d,
                         input logic ordy, input logic fl);
    a_if.in_valid = v; a_if.in_addr = ad; a_if.in_data = d;
    a_if.out_ready = ordy; flush_a = fl;
    @(posedge clk); #1;
  endtask

  task automatic drive_b(input logic v, input logic [2:0] ad, input logic [31:0] d,
                         input logic ordy);
    b_if.in_valid = v; b_if.in_addr = ad; b_if.in_data = d; b_if.out_ready = ordy;
    @(posedge clk); #1;
  endtask

  task automatic drive_c(input logic v, input logic [2:0] ad, input logic [31:0] d,
                         input logic ordy);
    c_if.in_valid = v; c_if.in_addr = ad; c_if.in_data = d; c_if.out_ready = ordy;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [255:0] exp_v;
    int unsigned  ord [8] = '{7, 3, 0, 5, 1, 6, 2, 4};
    int unsigned  c_fill [5] = '{0, 2, 3, 4, 5};

    rst = 1'b1; flush_a = 1'b0;
    a_if.in_valid = 0; a_if.in_addr = 0; a_if.in_data = 0; a_if.out_ready = 0;
    b_if.in_valid = 0; b_if.in_addr = 0; b_if.in_data = 0; b_if.out_ready = 0;
    c_if.in_valid = 0; c_if.in_addr = 0; c_if.in_data = 0; c_if.out_ready = 0;

    @(posedge clk); #1;
    chk_en = 1'b1;
    checkb("reset_in_ready", a_if.in_ready, 1'b1);
    checkb("reset_out_valid", a_if.out_valid, 1'b0);
    checkv("reset_vector", a_if.hash_vector, '0);
    checkv("reset_count", 256'(a_if.word_count), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    drive_a(0, 0, 0, 0, 0);
    checkb("release_in_ready", a_if.in_ready, 1'b1);

    // In-order fill with the SHA-256 IV seed pattern.
    for (int i = 0; i < 8; i++) begin
      drive_a(1, 3'(i), 32'h6a09e667 + 32'(i), 0, 0);
      checkb("fill_out_valid", a_if.out_valid, i == 7);
    end
    drive_a(0, 0, 0, 0, 0);
    checkv("fill_low_word", 256'(a_if.hash_vector[31:0]), 256'(32'h6a09e667));
    checkv("fill_high_word", 256'(a_if.hash_vector[255:224]), 256'(32'h6a09e66e));
    checkv("fill_count", 256'(a_if.word_count), 256'(8));
    checkb("fill_in_ready", a_if.in_ready, 1'b0);
    drive_a(0, 0, 0, 1, 0);
    checkv("take_vector", a_if.hash_vector, '0);
    checkb("take_in_ready", a_if.in_ready, 1'b1);

    // Duplicate write to slot 2.
    drive_a(1, 2, 32'd1, 0, 0);
    checkb("dup_first", a_if.dup_error, 1'b0);
    checkv("dup_count1", 256'(a_if.word_count), 256'(1));
    drive_a(1, 2, 32'd2, 0, 0);
    checkb("dup_pulse", a_if.dup_error, 1'b1);
    checkv("dup_slot2", 256'(a_if.hash_vector[95:64]), 256'(32'd2));
    checkv("dup_count2", 256'(a_if.word_count), 256'(1));
    drive_a(0, 0, 0, 0, 0);
    checkb("dup_one_shot", a_if.dup_error, 1'b0);
    drive_a(0, 0, 0, 0, 1);
    checkv("dup_flush_count", 256'(a_if.word_count), 256'(0));

    // Hold in DONE while in_valid toggles, then hand off.
    exp_v = '0;
    for (int i = 0; i < 8; i++) begin
      drive_a(1, 3'(i), 32'h01010101 * 32'(i + 1), 0, 0);
      exp_v[i*32 +: 32] = 32'h01010101 * 32'(i + 1);
    end
    for (int k = 0; k < 5; k++) begin
      drive_a(k[0], 3'(k), 32'hdead0000, 0, 0);
      checkv("hold_vector", a_if.hash_vector, exp_v);
      checkb("hold_in_ready", a_if.in_ready, 1'b0);
      checkb("hold_no_dup", a_if.dup_error, 1'b0);
    end
    drive_a(0, 0, 0, 1, 0);
    checkv("hold_take_vector", a_if.hash_vector, '0);
    checkb("hold_take_in_ready", a_if.in_ready, 1'b1);

    // Flush after four words, overriding in_valid and out_ready.
    for (int i = 0; i < 4; i++) drive_a(1, 3'(i), 32'h1000 + 32'(i), 0, 0);
    checkv("flush_pre_count", 256'(a_if.word_count), 256'(4));
    drive_a(1, 5, 32'hffff, 1, 1);
    checkv("flush_count", 256'(a_if.word_count), 256'(0));
    checkv("flush_vector", a_if.hash_vector, '0);
    checkb("flush_in_ready", a_if.in_ready, 1'b1);
    for (int i = 7; i >= 0; i--) drive_a(1, 3'(i), 32'h2000 + 32'(i), 0, 0);
    checkb("refill_out_valid", a_if.out_valid, 1'b1);
    checkv("refill_word0", 256'(a_if.hash_vector[31:0]), 256'(32'h2000));
    checkv("refill_word7", 256'(a_if.hash_vector[255:224]), 256'(32'h2007));

    // Reset while holding a completed vector.
    rst = 1'b1;
    drive_a(0, 0, 0, 0, 0);
    rst = 1'b0;
    checkv("rst_done_count", 256'(a_if.word_count), 256'(0));
    checkv("rst_done_vector", a_if.hash_vector, '0);
    checkb("rst_done_out_valid", a_if.out_valid, 1'b0);
    checkb("rst_done_in_ready", a_if.in_ready, 1'b1);
    for (int i = 0; i < 8; i++) drive_a(1, 3'(i), 32'h3000 + 32'(i), 0, 0);
    checkb("post_rst_out_valid", a_if.out_valid, 1'b1);
    checkv("post_rst_count", 256'(a_if.word_count), 256'(8));
    drive_a(0, 0, 0, 1, 0);
    drive_a(0, 0, 0, 0, 0);

    // Reversed word order, scattered arrival.
    for (int k = 0; k < 8; k++) begin
      drive_b(1, 3'(ord[k]), 32'hb0000000 + ord[k], 0);
      checkb("b_out_valid", b_if.out_valid, k == 7);
    end
    drive_b(0, 0, 0, 0);
    checkv("b_word0_top", 256'(b_if.hash_vector[255:224]), 256'(32'hb0000000));
    checkv("b_word7_bottom", 256'(b_if.hash_vector[31:0]), 256'(32'hb0000007));
    checkv("b_word4", 256'(b_if.hash_vector[127:96]), 256'(32'hb0000004));
    checkv("b_count", 256'(b_if.word_count), 256'(8));
    drive_b(0, 0, 0, 1);
    checkv("b_take_vector", 256'(b_if.hash_vector), '0);
    checkb("b_take_in_ready", b_if.in_ready, 1'b1);
    drive_b(0, 0, 0, 0);

    // Six-word instance: out-of-range indices 7 and 6.
    drive_c(1, 1, 32'h11, 0);
    drive_c(1, 7, 32'hff, 0);
    checkb("c_range_pulse", c_if.range_error, 1'b1);
    checkv("c_range_count", 256'(c_if.word_count), 256'(1));
    checkv("c_range_vector", 256'(c_if.hash_vector), 256'h11_0000_0000);
    drive_c(0, 0, 0, 0);
    checkb("c_range_one_shot", c_if.range_error, 1'b0);
    drive_c(1, 6, 32'hee, 0);
    checkb("c_range_edge", c_if.range_error, 1'b1);
    checkv("c_range_edge_count", 256'(c_if.word_count), 256'(1));
    for (int k = 0; k < 5; k++) drive_c(1, 3'(c_fill[k]), 32'h20 + c_fill[k], 0);
    checkb("c_out_valid", c_if.out_valid, 1'b1);
    checkv("c_count", 256'(c_if.word_count), 256'(6));
    drive_c(1, 7, 32'hff, 0);
    checkb("c_done_no_range", c_if.range_error, 1'b0);
    drive_c(0, 0, 0, 1);
    checkb("c_take_in_ready", c_if.in_ready, 1'b1);
    drive_c(0, 0, 0, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hash_word_assembler.md
HASH_WORD_ASSEMBLER -- requirements
Module: hash_word_assembler

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, the width of one hash data word.
REQ-002 SHALL have parameter NUM_WORDS, default 8, the number of words per assembled vector; legal range is 2..64.
REQ-003 SHALL have parameter WORD_ORDER, default 0: 0 places word i at bits [i*WORD_WIDTH +: WORD_WIDTH]; 1 places it at [(NUM_WORDS-1-i)*WORD_WIDTH +: WORD_WIDTH].
REQ-004 clock  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  abandons the current assembly and clears all state.
REQ-007 in_valid  in  1  word offered this cycle.
REQ-008 in_ready  out  1  block can accept a word.
REQ-009 in_addr  in  $clog2(NUM_WORDS)  word index.
REQ-010 in_data  in  WORD_WIDTH  word value.
REQ-011 out_valid  out  1  assembled vector is complete and held.
REQ-012 out_ready  in  1  consumer takes the vector.
REQ-013 hash_vector  out  NUM_WORDS*WORD_WIDTH  assembled vector.
REQ-014 word_count  out  $clog2(NUM_WORDS+1)  number of distinct words filled.
REQ-015 dup_error  out  1  one-cycle pulse when an accepted word targets an already-filled index.
REQ-016 range_error  out  1  one-cycle pulse when in_valid carries in_addr >= NUM_WORDS.

Function
REQ-017 SHALL implement two states: COLLECT and DONE.
REQ-018 in_ready SHALL be 1 in COLLECT and 0 in DONE; a word is accepted when in_valid & in_ready & in_addr < NUM_WORDS.
REQ-019 An accepted word SHALL be written into its slot per WORD_ORDER at the next edge; other slots are unchanged.
REQ-020 The block SHALL keep a NUM_WORDS-bit fill mask; an accepted word sets its bit.
REQ-021 A duplicate write SHALL overwrite the slot, leave word_count unchanged, and pulse dup_error in the following cycle.
REQ-022 An out-of-range address SHALL be discarded without changing the vector, mask or count, and SHALL pulse range_error in the following cycle.
REQ-023 Words MAY arrive in any order; completion SHALL depend only on the mask being all ones.
REQ-024 When the accepted word completes the mask, the state SHALL become DONE at the same edge; out_valid SHALL be 1 the cycle after the final word is accepted, which is one cycle of latency.
REQ-025 In DONE, hash_vector and word_count (= NUM_WORDS) SHALL stay stable until the handshake.
REQ-026 When out_valid & out_ready, the next edge SHALL clear the vector, mask and count and return to COLLECT; in_ready is 1 in the following cycle.
REQ-027 in_valid in DONE SHALL be ignored, with no error pulse.
REQ-028 flush SHALL clear the vector, mask, count and error pulses and force COLLECT at the next edge, from any state, overriding a simultaneous in_valid or out_ready.
REQ-029 word_count SHALL equal the popcount of the mask at all times.

Reset
REQ-030 On reset, which takes priority over flush, the block SHALL set state=COLLECT, hash_vector=0, mask=0, word_count=0, out_valid=0, dup_error=0 and range_error=0.
REQ-031 in_ready SHALL be 1 in the first cycle after reset is released.
REQ-032 Reset asserted mid-assembly or in DONE SHALL discard all partial or held data.

Structure
REQ-033 The state encoding typedef and the defaults for WORD_WIDTH and NUM_WORDS SHALL reside in a shared package, hash_pkg.
REQ-034 Slot placement, the WORD_ORDER index mapping, SHALL be a sub-module named hash_slot_map that is purely combinational and maps in_addr to a bit offset.
REQ-035 Each of hash_vector, the mask, word_count, the state and the error flags SHALL be a registered output with no combinational path from inputs to outputs, except in_ready, which is derived from state.

Verification
REQ-036 Defaults; write addr 0..7 in order with data 32'h6a09e667 + addr, one word per cycle -> out_valid in the cycle after addr 7; hash_vector[31:0]=32'h6a09e667 and [255:224]=32'h6a09e66e; word_count=8.
REQ-037 WORD_ORDER=1, write addr order 7,3,0,5,1,6,2,4 -> out_valid only after the 8th word; word 0 appears in [255:224].
REQ-038 Write addr 2 twice (data 1 then 2) -> dup_error pulses once; slot 2 = 2; word_count increments once.
REQ-039 NUM_WORDS=6, in_addr=7 -> range_error pulses; vector and count unchanged.
REQ-040 Hold out_ready=0 for 5 cycles in DONE with in_valid toggling -> vector stable, in_ready=0; then out_ready=1 -> vector=0 and in_ready=1 one cycle later.
REQ-041 flush after 4 words, and separately reset in DONE -> count=0, vector=0, state COLLECT; a subsequent full 8-word fill completes normally.
